mem_arbiter: RTL

Single-port memory arbiter sharing one word-addressed RAM between the instruction-fetch requester and the load/store requester of the rv32i core. It replaces the separate rom/ram fetch and data paths: both requesters issue request/grant transactions and receive read data one cycle after grant. Data accesses have fixed priority, bounded by a starvation limit that forces a fetch grant. A saturating conflict counter is exposed for performance inspection.

---
 rtl/mem_arbiter.sv | 107 ++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and load/store requesters.
// Data has fixed priority; a starvation limit forces a fetch grant under contention.
module mem_arbiter #(
    parameter int unsigned ADDR_W     = 7,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [15:0]       conflict_cnt
);

    localparam int unsigned STARVE_W   = 4;
    localparam int unsigned CONFLICT_W = 16;
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DATA  = 2'd2
    } owner_e;

    owner_e                owner_q, owner_d;
    logic [STARVE_W-1:0]   starve_q, starve_d;
    logic [CONFLICT_W-1:0] conflict_q, conflict_d;

    // Grant decision: data wins unless fetch has been denied STARVE_MAX cycles in a row
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!rst) begin
            if (d_req && i_req && (starve_q == STARVE_LIM)) begin
                i_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end else if (i_req) begin
                i_gnt = 1'b1;
            end
        end
    end

    // Winner drives the RAM port directly
    always_comb begin
        mem_en    = i_gnt | d_gnt;
        mem_addr  = d_gnt ? d_addr : i_addr;
        mem_we    = (d_gnt && d_we) ? d_be : 4'b0000;
        mem_wdata = d_wdata;
    end

    always_comb begin
        owner_d    = OWN_NONE;
        starve_d   = starve_q;
        conflict_d = conflict_q;

        if (i_gnt) begin
            owner_d = OWN_FETCH;
        end else if (d_gnt) begin
            owner_d = OWN_DATA;
        end

        if (i_gnt || !i_req) begin
            starve_d = '0;
        end else if (starve_q < STARVE_LIM) begin
            starve_d = starve_q + STARVE_W'(1);
        end

        if (i_req && d_req && (conflict_q != {CONFLICT_W{1'b1}})) begin
            conflict_d = conflict_q + CONFLICT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q    <= OWN_NONE;
            starve_q   <= '0;
            conflict_q <= '0;
        end else begin
            owner_q    <= owner_d;
            starve_q   <= starve_d;
            conflict_q <= conflict_d;
        end
    end

    assign i_rvalid     = (owner_q == OWN_FETCH);
    assign d_rvalid     = (owner_q == OWN_DATA);
    assign i_rdata      = mem_rdata;
    assign d_rdata      = mem_rdata;
    assign conflict_cnt = conflict_q;

endmodule
